// File: rtl/CSR_Typedefs.sv
// Shared CSR type package for the RV32I core.
// Also holds the pipeline controller FSM state type.
package CSR_Typedefs;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] csr_data_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    WAIT   = 2'd2
  } pipe_ctrl_state_e;

endpackage

// File: rtl/core_pipeline_ctrl_if.sv
// Control bundle between EX/ExceptionCtrl and the pipeline controller.
// master: controller side (drives stall/redirect/flush/WFI/retire).
interface core_pipeline_ctrl_if #(
  parameter int STALL_REQ_NUM = 1,
  parameter int PIPE_DEPTH    = 3
);
  localparam int SW = $clog2(STALL_REQ_NUM) + 1;

  logic [STALL_REQ_NUM-1:0] stall_req;
  logic                     inst_valid_ex;
  logic                     jump_en_ex;
  logic [31:0]              jump_addr_ex;
  logic                     exception_occurred;
  logic [31:0]              exception_jump_addr;
  logic                     wfi_ex;
  logic                     any_interrupt_come;

  logic                     stall_n;
  logic [SW-1:0]            stall_src;
  logic                     jump_en;
  logic [31:0]              jump_addr;
  logic [PIPE_DEPTH-1:0]    flush;
  logic                     hold_flag;
  logic                     clearing_pipeline;
  logic                     wait_for_interrupt;
  logic                     instruction_retire;
  logic [63:0]              retire_count;

  modport master (
    input  stall_req, inst_valid_ex, jump_en_ex, jump_addr_ex,
    input  exception_occurred, exception_jump_addr,
    input  wfi_ex, any_interrupt_come,
    output stall_n, stall_src, jump_en, jump_addr, flush,
    output hold_flag, clearing_pipeline, wait_for_interrupt,
    output instruction_retire, retire_count
  );

  modport slave (
    output stall_req, inst_valid_ex, jump_en_ex, jump_addr_ex,
    output exception_occurred, exception_jump_addr,
    output wfi_ex, any_interrupt_come,
    input  stall_n, stall_src, jump_en, jump_addr, flush,
    input  hold_flag, clearing_pipeline, wait_for_interrupt,
    input  instruction_retire, retire_count
  );
endinterface

// File: rtl/stall_prio_enc.sv
// Priority encoder: {valid, index} of lowest-index set request.
// Ports: i_req (N requests), o_src (valid in MSB, index below).
module stall_prio_enc #(
  parameter  int N  = 1,
  localparam int SW = $clog2(N) + 1
) (
  input  logic [N-1:0]  i_req,
  output logic [SW-1:0] o_src
);

  always_comb begin
    o_src = '0;
    // Walk high to low so the lowest index wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_src = SW'(i) | (SW'(1) << (SW - 1));
    end
  end

endmodule

// File: rtl/core_pipeline_ctrl.sv
// Pipeline controller: stall, redirect, flush, WFI, retire.
// Ports: clk, rst_n (async low), ctrl (core_pipeline_ctrl_if.master).
// Macro CORE_PIPE_CTRL_RETIRE_CNT_EN builds the 64-bit retire counter.
module core_pipeline_ctrl
  import CSR_Typedefs::*;
#(
  parameter int STALL_REQ_NUM = 1,
  parameter int PIPE_DEPTH    = 3
) (
  input logic                clk,
  input logic                rst_n,
  core_pipeline_ctrl_if.master ctrl
);

  localparam int CW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH - 1) : 1;
  localparam logic [CW-1:0] RF_INIT = CW'(PIPE_DEPTH - 2);

  pipe_ctrl_state_e r_state;
  logic [CW-1:0]    r_rf_cnt;

  logic w_wait;
  logic w_stall_n;
  logic w_redir;
  logic w_wfi_go;
  logic w_retire;

  assign w_wait    = (r_state == WAIT);
  // In WAIT the pipe is held by hold_flag/flush, not by stall_n.
  assign w_stall_n = w_wait | ~(|ctrl.stall_req);
  assign w_redir   = w_stall_n &
                     (ctrl.exception_occurred | ctrl.jump_en_ex);
  assign w_wfi_go  = ctrl.wfi_ex & w_stall_n &
                     ~ctrl.any_interrupt_come &
                     ~ctrl.exception_occurred;
  assign w_retire  = ctrl.inst_valid_ex & w_stall_n &
                     ~ctrl.exception_occurred & ~w_wait;

  stall_prio_enc #(.N(STALL_REQ_NUM)) u_enc (
    .i_req (ctrl.stall_req),
    .o_src (ctrl.stall_src)
  );

  assign ctrl.stall_n   = w_stall_n;
  assign ctrl.jump_en   = w_redir;
  assign ctrl.jump_addr = ctrl.exception_occurred ?
                          ctrl.exception_jump_addr :
                          ctrl.jump_addr_ex;
  // EX is only cleared by a trap; younger stages on any redirect/WAIT.
  assign ctrl.flush = {
    w_redir & ctrl.exception_occurred,
    {(PIPE_DEPTH-1){w_redir | w_wait}}
  };
  assign ctrl.instruction_retire = w_retire;

  assign ctrl.hold_flag          = w_wait;
  assign ctrl.wait_for_interrupt = w_wait;
  assign ctrl.clearing_pipeline  = (r_state == REFILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_rf_cnt <= '0;
    end else begin
      case (r_state)
        RUN, REFILL: begin
          if (w_redir) begin
            r_state  <= REFILL;
            r_rf_cnt <= RF_INIT;
          end else if (w_wfi_go) begin
            r_state  <= WAIT;
            r_rf_cnt <= '0;
          end else if (r_state == REFILL && w_stall_n) begin
            // Leave on the cycle the count runs out.
            if (r_rf_cnt <= CW'(1)) begin
              r_state  <= RUN;
              r_rf_cnt <= '0;
            end else begin
              r_rf_cnt <= r_rf_cnt - CW'(1);
            end
          end
        end
        WAIT: begin
          if (ctrl.any_interrupt_come) r_state <= RUN;
        end
        default: begin
          r_state  <= RUN;
          r_rf_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CORE_PIPE_CTRL_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retire_cnt <= '0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 64'd1;
  end

  assign ctrl.retire_count = r_retire_cnt;
`else
  assign ctrl.retire_count = '0;
`endif

endmodule

// File: tb/tb_core_pipeline_ctrl.sv
// Scoreboard bench for core_pipeline_ctrl (3 requesters, depth 4).
// Driver queues expected outputs; negedge monitor pops and compares.
module tb_core_pipeline_ctrl;

  localparam int SRN = 3;
  localparam int PD  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_pipeline_ctrl_if #(.STALL_REQ_NUM(SRN), .PIPE_DEPTH(PD)) bus ();

  core_pipeline_ctrl #(.STALL_REQ_NUM(SRN), .PIPE_DEPTH(PD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  typedef struct packed {
    logic        sn;
    logic [2:0]  src;
    logic        je;
    logic [31:0] ja;
    logic [3:0]  fl;
    logic        rt;
    logic        cl;
    logic        hd;
    logic        wi;
    logic [63:0] rc;
  } vec_t;

  vec_t  exp_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [63:0] m_cnt = '0;

  task automatic idle();
    bus.stall_req           = '0;
    bus.inst_valid_ex       = 1'b0;
    bus.jump_en_ex          = 1'b0;
    bus.jump_addr_ex        = '0;
    bus.exception_occurred  = 1'b0;
    bus.exception_jump_addr = '0;
    bus.wfi_ex              = 1'b0;
    bus.any_interrupt_come  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic sn,
                     input logic [2:0] src, input logic je,
                     input logic [31:0] ja, input logic [3:0] fl,
                     input logic rt, input logic cl,
                     input logic hd, input logic wi);
    vec_t v;
    v.sn = sn; v.src = src; v.je = je; v.ja = ja; v.fl = fl;
    v.rt = rt; v.cl = cl; v.hd = hd; v.wi = wi;
`ifdef CORE_PIPE_CTRL_RETIRE_CNT_EN
    v.rc = m_cnt;
`else
    v.rc = '0;
`endif
    exp_q.push_back(v);
    nm_q.push_back(nm);
    if (rt) m_cnt = m_cnt + 64'd1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    vec_t  e;
    vec_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      a.sn  = bus.stall_n;
      a.src = bus.stall_src;
      a.je  = bus.jump_en;
      a.ja  = bus.jump_addr;
      a.fl  = bus.flush;
      a.rt  = bus.instruction_retire;
      a.cl  = bus.clearing_pipeline;
      a.hd  = bus.hold_flag;
      a.wi  = bus.wait_for_interrupt;
      a.rc  = bus.retire_count;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display({"FAIL %s got sn=%b src=%b je=%b ja=%h fl=%b ",
                  "rt=%b cl=%b hd=%b wi=%b rc=%0d | want sn=%b ",
                  "src=%b je=%b ja=%h fl=%b rt=%b cl=%b hd=%b ",
                  "wi=%b rc=%0d"},
                 nm, a.sn, a.src, a.je, a.ja, a.fl, a.rt, a.cl,
                 a.hd, a.wi, a.rc, e.sn, e.src, e.je, e.ja, e.fl,
                 e.rt, e.cl, e.hd, e.wi, e.rc);
      end
    end
  end

  initial begin
    idle();
    @(posedge clk);
    #1;
    chk("reset", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("idle", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);

    // Stall blocks a simultaneous jump.
    bus.stall_req = 3'b110; bus.jump_en_ex = 1;
    bus.jump_addr_ex = 32'h100; bus.inst_valid_ex = 1;
    chk("stall_110", 0, 3'b101, 0, 32'h100, 4'b0000, 0, 0, 0, 0);
    bus.stall_req = 3'b011;
    chk("stall_011", 0, 3'b100, 0, 32'h100, 4'b0000, 0, 0, 0, 0);

    // Jump and 2-cycle refill.
    bus.stall_req = '0;
    chk("jump", 1, 3'b000, 1, 32'h100, 4'b0111, 1, 0, 0, 0);
    idle();
    chk("refill1", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    chk("refill2", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    chk("run_back", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);

    // Exception beats jump.
    bus.exception_occurred = 1; bus.exception_jump_addr = 32'h80;
    bus.jump_en_ex = 1; bus.jump_addr_ex = 32'h100;
    bus.inst_valid_ex = 1;
    chk("exc_jump", 1, 3'b000, 1, 32'h80, 4'b1111, 0, 0, 0, 0);
    idle();
    bus.stall_req = 3'b100;
    chk("rf_stall", 0, 3'b110, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    bus.stall_req = '0;
    chk("rf_a", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    bus.jump_en_ex = 1; bus.jump_addr_ex = 32'h44;
    bus.inst_valid_ex = 1;
    chk("rf_rejump", 1, 3'b000, 1, 32'h44, 4'b0111, 1, 1, 0, 0);
    idle();
    chk("rf_b", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    chk("rf_c", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    chk("run2", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);

    // Five retires with one stall cycle in between.
    bus.inst_valid_ex = 1;
    chk("ret1", 1, 3'b000, 0, 32'h0, 4'b0000, 1, 0, 0, 0);
    bus.stall_req = 3'b010;
    chk("ret_stall", 0, 3'b101, 0, 32'h0, 4'b0000, 0, 0, 0, 0);
    bus.stall_req = '0;
    for (int i = 0; i < 4; i++)
      chk("ret_n", 1, 3'b000, 0, 32'h0, 4'b0000, 1, 0, 0, 0);

    // WFI entry, sleep, wake.
    bus.wfi_ex = 1;
    chk("wfi_enter", 1, 3'b000, 0, 32'h0, 4'b0000, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      bus.stall_req = (i == 4) ? 3'b001 : 3'b000;
      chk("wait", 1, (i == 4) ? 3'b100 : 3'b000, 0, 32'h0,
          4'b0111, 0, 0, 1, 1);
    end
    bus.stall_req = '0;
    bus.any_interrupt_come = 1;
    chk("wait_irq", 1, 3'b000, 0, 32'h0, 4'b0111, 0, 0, 1, 1);
    bus.wfi_ex = 0;
    bus.exception_occurred = 1; bus.exception_jump_addr = 32'h200;
    chk("wake_trap", 1, 3'b000, 1, 32'h200, 4'b1111, 0, 0, 0, 0);
    idle();
    chk("rf_d", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);
    chk("rf_e", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);

    // WFI with interrupt already pending acts as a NOP.
    bus.wfi_ex = 1; bus.inst_valid_ex = 1;
    bus.any_interrupt_come = 1;
    chk("wfi_nop", 1, 3'b000, 0, 32'h0, 4'b0000, 1, 0, 0, 0);
    idle();
    chk("wfi_nop_run", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);

    // Exception beats WFI entry.
    bus.wfi_ex = 1; bus.inst_valid_ex = 1;
    bus.exception_occurred = 1; bus.exception_jump_addr = 32'h300;
    chk("exc_wfi", 1, 3'b000, 1, 32'h300, 4'b1111, 0, 0, 0, 0);
    idle();
    chk("exc_wfi_rf", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 1, 0, 0);

    // Asynchronous reset while still in REFILL.
    rst_n = 1'b0;
    m_cnt = '0;
    #1;
    chk("rst_mid", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("post_rst", 1, 3'b000, 0, 32'h0, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_pipeline_ctrl.md
# core_pipeline_ctrl

Parametrised pipeline controller for the RV32I core. It generalises the core's stall/jump/WFI control to any number of stall requesters and any pipeline depth. It sits between the EX stage, ExceptionCtrl, and the PC/stage registers. It arbitrates stalls, redirects, per-stage flushes, wait-for-interrupt, and instruction-retire accounting.

## Interface
- STALL_REQ_NUM, 1, number of stall requesters (≥1); bit 0 has the highest priority for `stall_src`.
- PIPE_DEPTH, 3, number of stage registers between the PC and EX, including EX (≥2).
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall_req  in  STALL_REQ_NUM  per-requester stall request (IO wait); level-sensitive.
- inst_valid_ex  in  1  EX holds a real (non-bubble) instruction.
- jump_en_ex  in  1  EX resolved a taken branch/jump.
- jump_addr_ex  in  32  branch/jump target.
- exception_occurred  in  1  ExceptionCtrl is taking a trap or mret this cycle.
- exception_jump_addr  in  32  trap/return target.
- wfi_ex  in  1  EX holds a WFI instruction.
- any_interrupt_come  in  1  an enabled interrupt is pending.
- stall_n  out  1  0 freezes all stage registers and the PC.
- stall_src  out  $clog2(STALL_REQ_NUM)+1  {valid, index} of the lowest-index active requester.
- jump_en  out  1  load the PC with `jump_addr`.
- jump_addr  out  32  redirect target.
- flush  out  PIPE_DEPTH  per-stage clear; bit 0 is the stage after the PC, bit PIPE_DEPTH-1 is EX.
- hold_flag  out  1  PC hold (WFI).
- clearing_pipeline  out  1  refill in progress after a redirect.
- wait_for_interrupt  out  1  the core is in the WFI sleep state.
- instruction_retire  out  1  one-cycle pulse per retired instruction.
- retire_count  out  64  number of retired instructions (see Configuration).

## Operation
- FSM states: RUN, REFILL, WAIT. Reset state is RUN.
- Stall: `stall_n = ~|stall_req` in RUN and REFILL. In WAIT, `stall_n` is 1 and the pipeline is held by `hold_flag` and `flush`. `stall_src` is the priority encode of `stall_req`; it reads {0,0} when no request is active.
- Redirect sources, in priority order: exception first, then jump. Both are gated by `stall_n`, so nothing redirects while stalled.
  - `jump_en = stall_n & (exception_occurred | jump_en_ex)`.
  - `jump_addr` is `exception_jump_addr` if `exception_occurred`, else `jump_addr_ex`.
- Flush on redirect:
  - `flush[PIPE_DEPTH-2:0]` = all ones, clearing every stage younger than EX.
  - `flush[PIPE_DEPTH-1]` = `exception_occurred`, so a trapped EX instruction does not advance.
  - The FSM moves to REFILL and loads counter `rf_cnt` with PIPE_DEPTH-2.
- REFILL:
  - `clearing_pipeline` = 1.
  - `rf_cnt` decrements on each cycle with `stall_n` = 1.
  - When `rf_cnt` reaches 0, the FSM returns to RUN. If PIPE_DEPTH = 2, REFILL lasts one cycle.
  - A new redirect during REFILL reloads `rf_cnt`.
- WFI:
  - If `wfi_ex & stall_n & ~any_interrupt_come & ~exception_occurred`, the FSM enters WAIT. If `any_interrupt_come` is already 1, WFI retires as a NOP.
  - In WAIT: `hold_flag` = 1, `wait_for_interrupt` = 1, and `flush[PIPE_DEPTH-2:0]` = all ones.
  - `any_interrupt_come` moves the FSM WAIT→RUN. ExceptionCtrl takes the trap in the following cycle.
- Retire: `instruction_retire = inst_valid_ex & stall_n & ~exception_occurred & (state != WAIT)`. The WFI instruction itself retires on the cycle it enters WAIT.
- Simultaneous events:
  - Exception beats jump.
  - Exception beats WFI entry.
  - Any stall request blocks all of the above for that cycle; the event is re-evaluated when `stall_n` returns to 1.

## Timing
- `stall_n`, `stall_src`, `jump_en`, `jump_addr`, `flush`, and `instruction_retire` are combinational, with zero-cycle latency. This is required because the stall is applied in EX.
- The FSM and `rf_cnt` are registered.
  - `clearing_pipeline`, `hold_flag`, and `wait_for_interrupt` decode from the registered state.
  - Registered-state effects appear on the cycle after the triggering event.
- Reset values:
  - state = RUN, `rf_cnt` = 0, `retire_count` = 0.
  - `hold_flag`, `wait_for_interrupt`, `clearing_pipeline` = 0.
  - The combinational outputs follow their inputs.
- Reset asserted mid-REFILL or mid-WAIT returns to RUN immediately (asynchronous).
- `retire_count` increments on the clock edge after each `instruction_retire` pulse and wraps from 2^64-1 to 0.

## Configuration
- `CORE_PIPE_CTRL_RETIRE_CNT_EN` defined: a 64-bit retired-instruction counter drives `retire_count` (minstret source).
- Not defined: `retire_count` is tied to 0 and no counter flops are built. `instruction_retire` is unaffected.

## Structure
- Add `pipe_ctrl_state_e` (RUN, REFILL, WAIT) to the shared `CSR_Typedefs` package next to the CSR types.
- One sub-module: `stall_prio_enc`, a parametrised priority encoder producing `stall_src`.
- The FSM, `rf_cnt`, and the optional counter live in the top module.

## Test plan
- STALL_REQ_NUM=3, stall_req=3'b110 → stall_n=0, stall_src={1,1}; a jump_en_ex asserted in the same cycle produces jump_en=0.
- PIPE_DEPTH=4, jump_en_ex=1, jump_addr_ex=0x100 → jump_en=1, jump_addr=0x100, flush=4'b0111; clearing_pipeline=1 for 2 cycles, then RUN.
- exception_occurred and jump_en_ex together, exception_jump_addr=0x80 → jump_addr=0x80, flush=4'b1111, instruction_retire=0.
- wfi_ex=1 with no interrupt pending → one retire pulse; hold_flag=1 and wait_for_interrupt=1 from the next cycle. Raising any_interrupt_come 10 cycles later → RUN on the next edge.
- 5 valid EX instructions with one stall cycle inserted → retire_count=5 with the macro defined; 0 without it.
- rst_n pulsed low during REFILL → state RUN, clearing_pipeline=0, retire_count=0 with no clock edge needed.
